apb_spi_nor_controller: RTL and testbench

- Bridges a single APB slave port to a byte-wide SPI-style NOR flash bus.
- An APB write launches a flash program frame of one 32-bit word; an APB read launches a flash read frame of one 32-bit word.
- The frame is serialised as one 8-bit byte per SPI clock period on an 8-bit MOSI/MISO bus.
- Sits between the APB interconnect and the external NOR flash device.

---
 rtl/apb_spi_nor_controller.sv | 131 +++++++++++++
 tb/tb_apb_spi_nor_controller.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/apb_spi_nor_controller.sv
// APB slave to byte-wide SPI NOR bridge: each APB access runs one 17/16-slot program/read frame.
// No wait states: s_css falls one cycle after accept; accesses arriving mid-frame are dropped.
module apb_spi_nor_controller #(
  parameter logic [7:0] CMD_WRITE = 8'h02,
  parameter logic [7:0] CMD_READ  = 8'h01,
  parameter int         PAD_SLOTS = 9
) (
  input  logic        p_clk,
  input  logic        p_reset,
  input  logic [31:0] p_addr,
  input  logic        p_write,
  input  logic        p_sel_x,
  input  logic        p_enable,
  input  logic [31:0] p_wdata,
  output logic [31:0] p_rdata,
  output logic [7:0]  s_mosi,
  input  logic [7:0]  s_miso,
  output logic        s_clk,
  output logic        s_css
);

  localparam logic [4:0] CMD_SLOT  = 5'(PAD_SLOTS);
  localparam logic [4:0] ADDR_SLOT = 5'(PAD_SLOTS + 1);
  localparam logic [4:0] DATA_SLOT = 5'(PAD_SLOTS + 4);
  localparam logic [4:0] CAP_SLOT  = 5'(PAD_SLOTS + 3);
  localparam logic [4:0] LAST_RD   = 5'(PAD_SLOTS + 6);
  localparam logic [4:0] LAST_WR   = 5'(PAD_SLOTS + 7);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state;
  logic        start_q;
  logic        phase_q;
  logic [4:0]  slot_q;
  logic [4:0]  nxt_slot;
  logic [4:0]  last_slot;
  logic [23:0] addr_q;
  logic [31:0] wdata_q;
  logic        dir_q;
  logic [23:0] rdata_sh;
  logic [7:0]  next_byte;
  logic        unused_addr_lsb;

  // the low address byte never goes to the flash
  assign unused_addr_lsb = ^p_addr[7:0];

  assign nxt_slot  = slot_q + 5'd1;
  assign last_slot = dir_q ? LAST_WR : LAST_RD;

  always_comb begin
    next_byte = 8'h00;
    if (nxt_slot == CMD_SLOT)
      next_byte = dir_q ? CMD_WRITE : CMD_READ;
    else if (nxt_slot == ADDR_SLOT)
      next_byte = addr_q[23:16];
    else if (nxt_slot == ADDR_SLOT + 5'd1)
      next_byte = addr_q[15:8];
    else if (nxt_slot == ADDR_SLOT + 5'd2)
      next_byte = addr_q[7:0];
    else if (dir_q && nxt_slot == DATA_SLOT)
      next_byte = wdata_q[31:24];
    else if (dir_q && nxt_slot == DATA_SLOT + 5'd1)
      next_byte = wdata_q[23:16];
    else if (dir_q && nxt_slot == DATA_SLOT + 5'd2)
      next_byte = wdata_q[15:8];
    else if (dir_q && nxt_slot == DATA_SLOT + 5'd3)
      next_byte = wdata_q[7:0];
  end

  always_ff @(posedge p_clk or posedge p_reset) begin
    if (p_reset) begin
      state    <= IDLE;
      start_q  <= 1'b0;
      phase_q  <= 1'b0;
      slot_q   <= 5'd0;
      addr_q   <= 24'd0;
      wdata_q  <= 32'd0;
      dir_q    <= 1'b0;
      rdata_sh <= 24'd0;
      p_rdata  <= 32'd0;
      s_mosi   <= 8'h00;
      s_clk    <= 1'b0;
      s_css    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (p_sel_x && p_enable) begin
            addr_q  <= p_addr[31:8];
            wdata_q <= p_wdata;
            dir_q   <= p_write;
            start_q <= 1'b1;
            phase_q <= 1'b0;
            slot_q  <= 5'd0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (start_q) begin
            // slot 0 L phase; slot 0 is always padding
            start_q  <= 1'b0;
            s_css    <= 1'b0;
            s_clk    <= 1'b0;
            s_mosi   <= 8'h00;
            rdata_sh <= 24'd0;
          end else if (!phase_q) begin
            s_clk   <= 1'b1;
            phase_q <= 1'b1;
          end else begin
            // end of H phase: s_clk falls, read bytes are sampled here
            s_clk   <= 1'b0;
            phase_q <= 1'b0;
            if (!dir_q && slot_q >= CAP_SLOT)
              rdata_sh <= {rdata_sh[15:0], s_miso};
            if (slot_q == last_slot) begin
              s_css  <= 1'b1;
              s_mosi <= 8'h00;
              state  <= IDLE;
              if (!dir_q)
                p_rdata <= {rdata_sh, s_miso};
            end else begin
              slot_q <= nxt_slot;
              s_mosi <= next_byte;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_spi_nor_controller.sv
// Directed bench for apb_spi_nor_controller with a small byte-wide flash model.
module tb_apb_spi_nor_controller;

  logic        p_clk = 1'b0;
  logic        p_reset;
  logic [31:0] p_addr;
  logic        p_write;
  logic        p_sel_x;
  logic        p_enable;
  logic [31:0] p_wdata;
  logic [31:0] p_rdata;
  logic [7:0]  s_mosi;
  logic [7:0]  s_miso;
  logic        s_clk;
  logic        s_css;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mosi_q[$];
  int          rise_cnt;
  logic [7:0]  resp[4];
  int          fall_n;
  int          rise_n;
  logic [31:0] rd_hist[64];

  apb_spi_nor_controller dut (
    .p_clk(p_clk), .p_reset(p_reset), .p_addr(p_addr), .p_write(p_write),
    .p_sel_x(p_sel_x), .p_enable(p_enable), .p_wdata(p_wdata), .p_rdata(p_rdata),
    .s_mosi(s_mosi), .s_miso(s_miso), .s_clk(s_clk), .s_css(s_css)
  );

  always #5 p_clk = ~p_clk;

  // flash model: samples s_mosi on s_clk rise, drives read data after rises of slots 12..15
  always @(posedge s_clk) begin
    mosi_q.push_back(s_mosi);
    rise_cnt++;
    if (rise_cnt >= 13 && rise_cnt <= 16) begin
      #1 s_miso = resp[rise_cnt-13];
    end
  end

  task automatic run_frame(input logic [31:0] a, input logic [31:0] d, input logic w, input int inj);
    mosi_q.delete();
    rise_cnt = 0;
    fall_n = -1;
    rise_n = -1;
    for (int i = 0; i < 64; i++) rd_hist[i] = 32'hx;
    @(negedge p_clk);
    p_sel_x = 1'b1; p_enable = 1'b0; p_addr = a; p_wdata = d; p_write = w;
    @(negedge p_clk);
    p_enable = 1'b1;
    @(posedge p_clk);
    #1 p_sel_x = 1'b0; p_enable = 1'b0;
    for (int n = 1; n <= 45; n++) begin
      @(posedge p_clk);
      #1;
      rd_hist[n] = p_rdata;
      if (fall_n < 0 && s_css == 1'b0) fall_n = n;
      else if (fall_n > 0 && rise_n < 0 && s_css == 1'b1) rise_n = n;
      if (inj > 0) begin
        if (n == inj) begin p_sel_x = 1'b1; p_write = 1'b0; p_addr = 32'hFFFF_FF00; end
        if (n == inj + 1) p_enable = 1'b1;
        if (n == inj + 3) begin p_sel_x = 1'b0; p_enable = 1'b0; end
      end
      if (rise_n > 0) break;
    end
  endtask

  task automatic test_reset;
    p_reset = 1'b1; p_sel_x = 1'b0; p_enable = 1'b0; p_write = 1'b0;
    p_addr = 32'd0; p_wdata = 32'd0; s_miso = 8'h00;
    repeat (2) @(negedge p_clk);
    checks++; if (s_css !== 1'b1) begin errors++; $display("FAIL reset_css got %b exp 1", s_css); end
    checks++; if (s_clk !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b exp 0", s_clk); end
    checks++; if (s_mosi !== 8'h00) begin errors++; $display("FAIL reset_mosi got %h exp 00", s_mosi); end
    checks++; if (p_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h exp 0", p_rdata); end
    p_reset = 1'b0;
    @(negedge p_clk);
  endtask

  task automatic test_write;
    logic [7:0] exp_b[17];
    for (int i = 0; i < 9; i++) exp_b[i] = 8'h00;
    exp_b[9] = 8'h02; exp_b[10] = 8'h00; exp_b[11] = 8'h00; exp_b[12] = 8'h00;
    exp_b[13] = 8'hFF; exp_b[14] = 8'h00; exp_b[15] = 8'hFF; exp_b[16] = 8'h00;
    run_frame(32'h0, 32'hFF00FF00, 1'b1, 0);
    checks++; if (fall_n !== 1) begin errors++; $display("FAIL wr_css_fall got E+%0d exp E+1", fall_n); end
    checks++; if (rise_n !== 35) begin errors++; $display("FAIL wr_css_rise got E+%0d exp E+35", rise_n); end
    checks++; if (mosi_q.size() !== 17) begin errors++; $display("FAIL wr_rises got %0d exp 17", mosi_q.size()); end
    for (int i = 0; i < 17; i++) begin
      checks++;
      if (i >= mosi_q.size() || mosi_q[i] !== exp_b[i]) begin
        errors++; $display("FAIL wr_byte[%0d] got %h exp %h", i, (i < mosi_q.size()) ? mosi_q[i] : 8'hxx, exp_b[i]);
      end
    end
    checks++; if (s_clk !== 1'b0 || s_mosi !== 8'h00) begin errors++; $display("FAIL wr_end_idle got clk=%b mosi=%h exp 0/00", s_clk, s_mosi); end
    checks++; if (p_rdata !== 32'd0) begin errors++; $display("FAIL wr_rdata_kept got %h exp 0", p_rdata); end
  endtask

  task automatic test_read;
    resp[0] = 8'hFF; resp[1] = 8'h00; resp[2] = 8'hFF; resp[3] = 8'h00;
    run_frame(32'h0, 32'h0, 1'b0, 0);
    checks++; if (fall_n !== 1) begin errors++; $display("FAIL rd_css_fall got E+%0d exp E+1", fall_n); end
    checks++; if (rise_n !== 33) begin errors++; $display("FAIL rd_css_rise got E+%0d exp E+33", rise_n); end
    checks++; if (mosi_q.size() !== 16) begin errors++; $display("FAIL rd_rises got %0d exp 16", mosi_q.size()); end
    checks++; if (mosi_q[9] !== 8'h01) begin errors++; $display("FAIL rd_cmd got %h exp 01", mosi_q[9]); end
    checks++; if (rd_hist[32] !== 32'd0) begin errors++; $display("FAIL rd_early got %h exp 0", rd_hist[32]); end
    checks++; if (rd_hist[33] !== 32'hFF00FF00) begin errors++; $display("FAIL rd_data got %h exp FF00FF00", rd_hist[33]); end
  endtask

  task automatic test_read_addr;
    resp[0] = 8'hA5; resp[1] = 8'h5A; resp[2] = 8'hC3; resp[3] = 8'h3C;
    run_frame(32'h12345678, 32'h0, 1'b0, 0);
    checks++; if (mosi_q.size() !== 16) begin errors++; $display("FAIL ra_rises got %0d exp 16", mosi_q.size()); end
    checks++; if (mosi_q[10] !== 8'h12) begin errors++; $display("FAIL ra_a2 got %h exp 12", mosi_q[10]); end
    checks++; if (mosi_q[11] !== 8'h34) begin errors++; $display("FAIL ra_a1 got %h exp 34", mosi_q[11]); end
    checks++; if (mosi_q[12] !== 8'h56) begin errors++; $display("FAIL ra_a0 got %h exp 56", mosi_q[12]); end
    checks++; if (rd_hist[32] !== 32'hFF00FF00) begin errors++; $display("FAIL ra_prev got %h exp FF00FF00", rd_hist[32]); end
    checks++; if (rd_hist[33] !== 32'hA55AC33C) begin errors++; $display("FAIL ra_data got %h exp A55AC33C", rd_hist[33]); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_b[7];
    exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(32'hAABBCC00, 32'h11223344, 1'b1, 10);
    checks++; if (rise_n !== 35) begin errors++; $display("FAIL b2b_rise got E+%0d exp E+35", rise_n); end
    checks++; if (mosi_q.size() !== 17) begin errors++; $display("FAIL b2b_rises got %0d exp 17", mosi_q.size()); end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (mosi_q[10+i] !== exp_b[i]) begin
        errors++; $display("FAIL b2b_byte[%0d] got %h exp %h", 10 + i, mosi_q[10+i], exp_b[i]);
      end
    end
    checks++; if (p_rdata !== 32'hA55AC33C) begin errors++; $display("FAIL b2b_rdata got %h exp A55AC33C", p_rdata); end
    resp[0] = 8'h01; resp[1] = 8'h02; resp[2] = 8'h03; resp[3] = 8'h04;
    run_frame(32'h0, 32'h0, 1'b0, 0);
    checks++; if (fall_n !== 1) begin errors++; $display("FAIL b2b_next_fall got E+%0d exp E+1", fall_n); end
    checks++; if (rd_hist[33] !== 32'h01020304) begin errors++; $display("FAIL b2b_next_data got %h exp 01020304", rd_hist[33]); end
  endtask

  task automatic test_setup_only;
    logic css_low_seen;
    css_low_seen = 1'b0;
    rise_cnt = 0;
    @(negedge p_clk);
    p_sel_x = 1'b1; p_enable = 1'b0; p_write = 1'b1;
    repeat (6) begin
      @(posedge p_clk); #1;
      if (s_css !== 1'b1) css_low_seen = 1'b1;
    end
    p_sel_x = 1'b0;
    repeat (4) begin
      @(posedge p_clk); #1;
      if (s_css !== 1'b1) css_low_seen = 1'b1;
    end
    checks++; if (css_low_seen !== 1'b0) begin errors++; $display("FAIL setup_css got low exp high"); end
    checks++; if (rise_cnt !== 0) begin errors++; $display("FAIL setup_sclk got %0d rises exp 0", rise_cnt); end
  endtask

  task automatic test_reset_mid;
    @(negedge p_clk);
    p_sel_x = 1'b1; p_enable = 1'b0; p_addr = 32'h0; p_wdata = 32'hCAFEF00D; p_write = 1'b1;
    @(negedge p_clk);
    p_enable = 1'b1;
    @(posedge p_clk);
    #1 p_sel_x = 1'b0; p_enable = 1'b0;
    repeat (23) @(posedge p_clk);
    #3 p_reset = 1'b1;
    #1;
    checks++; if (s_css !== 1'b1) begin errors++; $display("FAIL rstmid_css got %b exp 1", s_css); end
    checks++; if (s_clk !== 1'b0) begin errors++; $display("FAIL rstmid_sclk got %b exp 0", s_clk); end
    checks++; if (s_mosi !== 8'h00) begin errors++; $display("FAIL rstmid_mosi got %h exp 00", s_mosi); end
    @(negedge p_clk);
    p_reset = 1'b0;
    resp[0] = 8'hDE; resp[1] = 8'hAD; resp[2] = 8'hBE; resp[3] = 8'hEF;
    run_frame(32'h00ABCD00, 32'h0, 1'b0, 0);
    checks++; if (fall_n !== 1) begin errors++; $display("FAIL rstmid_fall got E+%0d exp E+1", fall_n); end
    checks++; if (rise_n !== 33) begin errors++; $display("FAIL rstmid_rise got E+%0d exp E+33", rise_n); end
    checks++; if (mosi_q[11] !== 8'hAB) begin errors++; $display("FAIL rstmid_addr got %h exp AB", mosi_q[11]); end
    checks++; if (rd_hist[33] !== 32'hDEADBEEF) begin errors++; $display("FAIL rstmid_data got %h exp DEADBEEF", rd_hist[33]); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_read_addr();
    test_back_to_back();
    test_setup_only();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
